// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the sequential wide adder.
// Macro WIDE_ADD_SUB_EN (consumed by wide_add_seq) compiles subtraction support in.
package wide_add_pkg;

  localparam int unsigned DATA_SIZE_DEF = 16;
  localparam int unsigned NUM_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index needs at least one bit even when there is a single slice.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_prefix_adder_cin.sv
// Combinational Kogge-Stone prefix adder with carry-in, one slice of wide_add_seq.
// Carry-in is folded into the bit-0 generate term so the prefix tree needs no extra level.
module prefix_adder_cin #(
  parameter int unsigned DATA_SIZE = 16
) (
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 cin,
  output logic [DATA_SIZE-1:0] s,
  output logic                 cout
);

  localparam int unsigned LEVELS = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  logic [DATA_SIZE-1:0] gk [LEVELS+1];
  logic [DATA_SIZE-1:0] pk [LEVELS+1];

  always_comb begin
    pk[0]    = a ^ b;
    gk[0]    = a & b;
    gk[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    for (int unsigned l = 0; l < LEVELS; l++) begin
      gk[l+1] = gk[l];
      pk[l+1] = pk[l];
      for (int unsigned i = (32'd1 << l); i < DATA_SIZE; i++) begin
        gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i - (32'd1 << l)]);
        pk[l+1][i] = pk[l][i] & pk[l][i - (32'd1 << l)];
      end
    end
  end

  // gk[LEVELS][i] is the carry into bit i+1, including cin.
  always_comb begin
    s    = '0;
    s[0] = pk[0][0] ^ cin;
    for (int unsigned i = 1; i < DATA_SIZE; i++) begin
      s[i] = pk[0][i] ^ gk[LEVELS][i-1];
    end
    cout = gk[LEVELS][DATA_SIZE-1];
  end

endmodule

// File: rtl/wide_add_seq.sv
// Sequential wide adder: one DATA_SIZE slice per cycle through a single prefix adder.
// Define WIDE_ADD_SUB_EN to enable a - b when sub is captured high.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_SIZE*NUM_WORDS-1:0] a,
  input  logic [DATA_SIZE*NUM_WORDS-1:0] b,
  input  logic                           sub,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_SIZE*NUM_WORDS-1:0] s,
  output logic                           cout
);

  localparam int unsigned    W        = DATA_SIZE * NUM_WORDS;
  localparam int unsigned    IW       = idx_width(NUM_WORDS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_WORDS - 1);

  state_t               state, state_nxt;
  logic [W-1:0]         a_r, b_r, s_r;
  logic [IW-1:0]        idx;
  logic                 carry, cout_r;
  logic                 accept, last_slice;
  logic                 init_carry;
  logic [DATA_SIZE-1:0] slice_a, slice_b, slice_s;
  logic                 slice_cout;

  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == LAST_IDX);
  assign slice_a    = a_r[idx*DATA_SIZE +: DATA_SIZE];

`ifdef WIDE_ADD_SUB_EN
  logic sub_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_r <= 1'b0;
    end else if (accept) begin
      sub_r <= sub;
    end
  end

  // Two's-complement subtract: invert b slices, seed the first carry with 1.
  assign slice_b    = b_r[idx*DATA_SIZE +: DATA_SIZE] ^ {DATA_SIZE{sub_r}};
  assign init_carry = sub;
`else
  logic sub_unused;

  assign sub_unused = sub;
  assign slice_b    = b_r[idx*DATA_SIZE +: DATA_SIZE];
  assign init_carry = 1'b0;
`endif

  prefix_adder_cin #(
    .DATA_SIZE(DATA_SIZE)
  ) u_slice_add (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry),
    .s   (slice_s),
    .cout(slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      idx   <= '0;
      carry <= init_carry;
    end else if (state == RUN) begin
      s_r[idx*DATA_SIZE +: DATA_SIZE] <= slice_s;
      carry <= slice_cout;
      if (last_slice) begin
        idx    <= '0;
        cout_r <= slice_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign s    = s_r;
  assign cout = cout_r;

endmodule
